// File: rtl/airlock_pkg.sv
// Shared constants for the airlock chamber responder: command/response codes,
// FSM state encoding, tick counter width and the interlock legality rule.
package airlock_pkg;

  localparam int TICK_W = 4;

  localparam logic [1:0] CMD_PRESSURIZE   = 2'b00;
  localparam logic [1:0] CMD_EVACUATE     = 2'b01;
  localparam logic [1:0] CMD_TOGGLE_OUTER = 2'b10;
  localparam logic [1:0] CMD_TOGGLE_INNER = 2'b11;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_REJECT  = 2'b01;
  localparam logic [1:0] RSP_ABORTED = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_PORT = 3'd1,
    ST_FILL      = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_RESPOND   = 3'd4
  } state_t;

  // Interlock rule: a port may only open toward the side whose pressure matches,
  // and only while the opposite port is shut. Closing a port is always safe.
  function automatic logic cmd_legal(input logic [1:0] cmd, input logic press,
                                     input logic outer, input logic inner);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_PRESSURIZE:   ok = !outer && !inner && !press;
      CMD_EVACUATE:     ok = !outer && !inner &&  press;
      CMD_TOGGLE_OUTER: ok = outer || (press && !inner);
      CMD_TOGGLE_INNER: ok = inner || (!press && !outer);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tick_countdown.sv
// Loadable down counter in divider ticks; shared by every timed chamber/port action.
module tick_countdown
  import airlock_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic [TICK_W-1:0] LoadVal,
  input  logic              Tick,
  output logic [TICK_W-1:0] Count,
  output logic              Zero
);

  logic [TICK_W-1:0] cnt;

  // Load wins over Tick; counting stops at zero.
  always_ff @(posedge Clock) begin
    if (Reset)                 cnt <= '0;
    else if (Load)             cnt <= LoadVal;
    else if (Tick && cnt != 0) cnt <= cnt - 1'b1;
  end

  assign Count = cnt;
  assign Zero  = (cnt == '0);

endmodule

// File: rtl/airlock_chamber_responder.sv
// Airlock chamber/port responder: valid/ready command intake, interlock checks,
// timed fill/drain/port moves in divider ticks, one response pulse per command.
// Optional feature: define AIRLOCK_ABORT_EN to add the CmdAbort input.
module airlock_chamber_responder
  import airlock_pkg::*;
#(
  parameter int unsigned PRESS_TICKS = 5,
  parameter int unsigned EVAC_TICKS  = 5,
  parameter int unsigned PORT_TICKS  = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Tick,
  input  logic              CmdValid,
  input  logic [1:0]        CmdCode,
  output logic              CmdReady,
  output logic              RspValid,
  output logic [1:0]        RspCode,
  output logic              Pressurized,
  output logic              OuterOpen,
  output logic              InnerOpen,
  output logic              Busy,
  output logic [TICK_W-1:0] Remaining
`ifdef AIRLOCK_ABORT_EN
  ,
  input  logic              CmdAbort
`endif
);

  localparam logic [TICK_W-1:0] PRESS_N = PRESS_TICKS[TICK_W-1:0];
  localparam logic [TICK_W-1:0] EVAC_N  = EVAC_TICKS[TICK_W-1:0];
  localparam logic [TICK_W-1:0] PORT_N  = PORT_TICKS[TICK_W-1:0];

  state_t            state, nxt;
  logic              press_q, outer_q, inner_q, move_outer_q;
  logic [1:0]        rsp_q, rsp_d;
  logic              ld;
  logic [TICK_W-1:0] ld_val;
  logic              commit;
  logic              busy;
  logic              last_tick;
  logic              abort_req;
  logic [TICK_W-1:0] cnt_val;
  logic              cnt_zero;

`ifdef AIRLOCK_ABORT_EN
  assign abort_req = CmdAbort;
`else
  assign abort_req = 1'b0;
`endif

  assign busy = (state == ST_MOVE_PORT) || (state == ST_FILL) || (state == ST_DRAIN);
  // Counter at exactly one: the next tick finishes the action.
  assign last_tick = busy && Tick && !cnt_zero && (cnt_val[TICK_W-1:1] == '0);

  // Ticks only count inside a timed state, so a tick in the accept cycle is ignored.
  tick_countdown u_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .Load    (ld),
    .LoadVal (ld_val),
    .Tick    (Tick && busy),
    .Count   (cnt_val),
    .Zero    (cnt_zero)
  );

  // Next-state, counter load and response selection.
  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = '0;
    commit = 1'b0;
    rsp_d  = rsp_q;
    case (state)
      ST_IDLE: begin
        if (CmdValid) begin
          if (cmd_legal(CmdCode, press_q, outer_q, inner_q)) begin
            ld = 1'b1;
            case (CmdCode)
              CMD_PRESSURIZE: begin nxt = ST_FILL;      ld_val = PRESS_N; end
              CMD_EVACUATE:   begin nxt = ST_DRAIN;     ld_val = EVAC_N;  end
              default:        begin nxt = ST_MOVE_PORT; ld_val = PORT_N;  end
            endcase
          end else begin
            nxt   = ST_RESPOND;
            rsp_d = RSP_REJECT;
          end
        end
      end
      ST_MOVE_PORT, ST_FILL, ST_DRAIN: begin
        // Abort outranks a completing tick in the same cycle.
        if (abort_req) begin
          nxt    = ST_RESPOND;
          rsp_d  = RSP_ABORTED;
          ld     = 1'b1;
          ld_val = '0;
        end else if (last_tick) begin
          nxt    = ST_RESPOND;
          rsp_d  = RSP_OK;
          commit = 1'b1;
        end
      end
      ST_RESPOND: nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  // State register, chamber/port status and the pending port selection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      press_q      <= 1'b0;
      outer_q      <= 1'b0;
      inner_q      <= 1'b0;
      move_outer_q <= 1'b0;
      rsp_q        <= RSP_OK;
    end else begin
      state <= nxt;
      rsp_q <= rsp_d;
      if (state == ST_IDLE && CmdValid) move_outer_q <= (CmdCode == CMD_TOGGLE_OUTER);
      if (commit) begin
        case (state)
          ST_FILL:  press_q <= 1'b1;
          ST_DRAIN: press_q <= 1'b0;
          ST_MOVE_PORT: begin
            if (move_outer_q) outer_q <= !outer_q;
            else              inner_q <= !inner_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign CmdReady    = (state == ST_IDLE);
  assign RspValid    = (state == ST_RESPOND);
  assign RspCode     = RspValid ? rsp_q : RSP_OK;
  assign Pressurized = press_q;
  assign OuterOpen   = outer_q;
  assign InnerOpen   = inner_q;
  assign Busy        = busy;
  assign Remaining   = cnt_val;

endmodule

// File: tb/tb_airlock_chamber_responder.sv
// Bench for airlock_chamber_responder: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a command-level model.
module tb_airlock_chamber_responder;

`ifdef AIRLOCK_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick = 1'b0;
  logic       CmdValid = 1'b0;
  logic [1:0] CmdCode = 2'b00;
  logic       abort_in = 1'b0;
  logic       CmdReady, RspValid, Pressurized, OuterOpen, InnerOpen, Busy;
  logic [1:0] RspCode;
  logic [3:0] Remaining;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  airlock_chamber_responder dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Tick        (Tick),
    .CmdValid    (CmdValid),
    .CmdCode     (CmdCode),
    .CmdReady    (CmdReady),
    .RspValid    (RspValid),
    .RspCode     (RspCode),
    .Pressurized (Pressurized),
    .OuterOpen   (OuterOpen),
    .InnerOpen   (InnerOpen),
    .Busy        (Busy),
    .Remaining   (Remaining)
`ifdef AIRLOCK_ABORT_EN
    ,
    .CmdAbort    (abort_in)
`endif
  );

  // Command-level model: phase 0 waiting, 1 timed action, 2 response pulse.
  int         m_phase = 0;
  int         m_rem = 0;
  int         m_kind = 0;
  bit         m_press = 0, m_outer = 0, m_inner = 0;
  logic [1:0] m_rsp = 2'b00;

  function automatic bit allowed(input int code, input bit p, input bit o, input bit i);
    case (code)
      0: return !o && !i && !p;
      1: return !o && !i && p;
      2: return o || (p && !i);
      default: return i || (!p && !o);
    endcase
  endfunction

  function automatic int duration(input int code);
    if (code == 0) return 5;
    if (code == 1) return 3 + 2;
    return 2;
  endfunction

  task automatic model_step(input bit v, input int code, input bit t, input bit r, input bit a);
    if (r) begin
      m_phase = 0; m_rem = 0; m_press = 0; m_outer = 0; m_inner = 0; m_rsp = 2'b00;
    end else if (m_phase == 0) begin
      if (v) begin
        if (allowed(code, m_press, m_outer, m_inner)) begin
          m_phase = 1; m_kind = code; m_rem = duration(code);
        end else begin
          m_phase = 2; m_rsp = 2'b01;
        end
      end
    end else if (m_phase == 1) begin
      if (ABORT_EN && a) begin
        m_phase = 2; m_rsp = 2'b10; m_rem = 0;
      end else if (t) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          case (m_kind)
            0: m_press = 1;
            1: m_press = 0;
            2: m_outer = !m_outer;
            default: m_inner = !m_inner;
          endcase
          m_phase = 2; m_rsp = 2'b00;
        end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("cmd_ready",   {3'b0, CmdReady},    {3'b0, m_phase == 0});
    check("rsp_valid",   {3'b0, RspValid},    {3'b0, m_phase == 2});
    if (m_phase == 2) check("rsp_code", {2'b0, RspCode}, {2'b0, m_rsp});
    check("pressurized", {3'b0, Pressurized}, {3'b0, m_press});
    check("outer_open",  {3'b0, OuterOpen},   {3'b0, m_outer});
    check("inner_open",  {3'b0, InnerOpen},   {3'b0, m_inner});
    check("busy",        {3'b0, Busy},        {3'b0, m_phase == 1});
    check("remaining",   Remaining,           m_rem[3:0]);
  endtask

  // One clock: drive, let the DUT sample, advance the model, compare on the falling edge.
  task automatic cyc(input bit v, input int code, input bit t, input bit r, input bit a);
    Reset = r; CmdValid = v; CmdCode = code[1:0]; Tick = t; abort_in = a;
    @(posedge Clock);
    model_step(v, code, t, r, a);
    @(negedge Clock);
    compare_model();
  endtask

  task automatic run_cmd(input int code, input int n);
    cyc(1, code, 0, 0, 0);
    repeat (n) cyc(0, 0, 1, 0, 0);
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("lit_reset_ready", {3'b0, CmdReady}, 4'd1);
    check("lit_reset_press", {3'b0, Pressurized}, 4'd0);
    check("lit_reset_rem", Remaining, 4'd0);

    // Pressurize: five ticks, response the cycle after the fifth
    cyc(1, 0, 0, 0, 0);
    check("lit_fill_rem", Remaining, 4'd5);
    check("lit_fill_busy", {3'b0, Busy}, 4'd1);
    repeat (4) cyc(0, 0, 1, 0, 0);
    check("lit_fill_rem1", Remaining, 4'd1);
    check("lit_fill_norsp", {3'b0, RspValid}, 4'd0);
    cyc(0, 0, 1, 0, 0);
    check("lit_fill_rsp", {3'b0, RspValid}, 4'd1);
    check("lit_fill_ok", {2'b0, RspCode}, 4'd0);
    check("lit_fill_press", {3'b0, Pressurized}, 4'd1);
    cyc(0, 0, 0, 0, 0);
    check("lit_ready_back", {3'b0, CmdReady}, 4'd1);

    // Pressurized: open outer (2 ticks, old position shown while moving), then evacuate rejected
    cyc(1, 2, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("lit_outer_moving", {3'b0, OuterOpen}, 4'd0);
    cyc(0, 0, 1, 0, 0);
    check("lit_outer_open", {3'b0, OuterOpen}, 4'd1);
    check("lit_outer_rsp", {3'b0, RspValid}, 4'd1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("lit_evac_reject", {2'b0, RspCode}, 4'd1);
    cyc(0, 0, 0, 0, 0);

    // Close outer, evacuate
    run_cmd(2, 2); cyc(0, 0, 0, 0, 0);
    run_cmd(1, 5); cyc(0, 0, 0, 0, 0);
    check("lit_evacuated", {3'b0, Pressurized}, 4'd0);

    // Evacuated: opening outer rejected immediately
    cyc(1, 2, 0, 0, 0);
    check("lit_outer_reject", {2'b0, RspCode}, 4'd1);
    check("lit_outer_stays", {3'b0, OuterOpen}, 4'd0);
    cyc(0, 0, 0, 0, 0);

    // Tick coincident with accept is ignored
    cyc(1, 0, 1, 0, 0);
    check("lit_acc_tick_rem", Remaining, 4'd5);
    repeat (4) cyc(0, 0, 1, 0, 0);
    check("lit_acc_tick_norsp", {3'b0, RspValid}, 4'd0);
    cyc(0, 0, 1, 0, 0);
    check("lit_acc_tick_rsp", {3'b0, RspValid}, 4'd1);
    cyc(0, 0, 0, 0, 0);
    run_cmd(1, 5); cyc(0, 0, 0, 0, 0);

    // Reset in the middle of a fill
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    check("lit_mid_rem", Remaining, 4'd2);
    cyc(0, 0, 0, 1, 0);
    check("lit_rst_ready", {3'b0, CmdReady}, 4'd1);
    check("lit_rst_press", {3'b0, Pressurized}, 4'd0);
    check("lit_rst_norsp", {3'b0, RspValid}, 4'd0);
    cyc(0, 0, 0, 0, 0);
    check("lit_rst_norsp2", {3'b0, RspValid}, 4'd0);

`ifdef AIRLOCK_ABORT_EN
    // Abort during drain with two ticks left, on a tick cycle
    run_cmd(0, 5); cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    check("lit_abort_rem", Remaining, 4'd2);
    cyc(0, 0, 1, 0, 1);
    check("lit_abort_code", {2'b0, RspCode}, 4'd2);
    check("lit_abort_press", {3'b0, Pressurized}, 4'd1);
    check("lit_abort_rem0", Remaining, 4'd0);
    cyc(0, 0, 0, 0, 0);
`endif

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      cyc($urandom_range(1, 0) == 1, int'($urandom_range(3, 0)),
          $urandom_range(9, 0) < 3, $urandom_range(299, 0) == 0,
          ABORT_EN && ($urandom_range(19, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
